// File: rtl/tc_to_sm_pkg.sv
// Shared types and constants for the two's-complement to sign-magnitude decoder.
package tc_to_sm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Bit-counter width; it must count 0..WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/tc_to_sm_half_adder.sv
// Single-bit half adder used as the serial carry cell of the decoder.
module tc_to_sm_half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;

endmodule

// File: rtl/tc_to_sm.sv
// Bit-serial two's-complement to sign-magnitude decoder, one bit per clock, LSB first.
// Optional overflow flag for the most-negative operand is enabled by TC2SM_OVF_EN.
module tc_to_sm
  import tc_to_sm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [WIDTH-1:0] magnitude
`ifdef TC2SM_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] mag_q;
  logic [WIDTH-1:0] mag_d;
  logic [CW-1:0]    cnt_q;
  logic             sign_q;
  logic             carry_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             x_bit;
  logic             sum_bit;
  logic             cout_bit;
`ifdef TC2SM_OVF_EN
  logic             ovf_q;
`endif

  // Conditional inversion plus the +1 seeded through the initial carry.
  assign x_bit = shreg_q[0] ^ sign_q;

  tc_to_sm_half_adder u_ha (
    .a_i    (x_bit),
    .b_i    (carry_q),
    .sum_o  (sum_bit),
    .carry_o(cout_bit)
  );

  assign mag_d = {sum_bit, mag_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      mag_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef TC2SM_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shreg_q    <= operand;
            sign_q     <= operand[WIDTH-1];
            carry_q    <= operand[WIDTH-1];
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          shreg_q <= shreg_q >> 1;
          mag_q   <= mag_d;
          carry_q <= cout_bit;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef TC2SM_OVF_EN
            // Only -2^(WIDTH-1) yields this magnitude; positives top out one lower.
            ovf_q       <= (mag_d == MOST_NEG);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
`ifdef TC2SM_OVF_EN
            ovf_q       <= 1'b0;
`endif
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sign      = sign_q;
  assign magnitude = mag_q;
`ifdef TC2SM_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_tc_to_sm.sv
// Directed testbench for tc_to_sm (WIDTH=8); ovf checks compile in with TC2SM_OVF_EN.
module tb_tc_to_sm;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] operand;
  logic         out_valid;
  logic         out_ready;
  logic         sign;
  logic [W-1:0] magnitude;
`ifdef TC2SM_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tc_to_sm #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .operand  (operand),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sign     (sign),
    .magnitude(magnitude)
`ifdef TC2SM_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Accept one operand, count edges to out_valid, leave DUT in DONE.
  task automatic send_and_wait(input logic [W-1:0] op, output int lat);
    @(negedge clk);
    operand  = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
    check({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] op,
                        input logic exp_sign, input logic [W-1:0] exp_mag,
                        input logic exp_ovf);
    int lat;
    send_and_wait(op, lat);
    check({tag, " latency"}, 32'(lat), 32'd8);
    check({tag, " sign"}, 32'(sign), 32'(exp_sign));
    check({tag, " mag"}, 32'(magnitude), 32'(exp_mag));
`ifdef TC2SM_OVF_EN
    check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf) begin end
`endif
    release_result(tag);
  endtask

  initial begin
    int lat;
    int t0, t1, n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    operand   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst sign", 32'(sign), 32'd0);
    check("rst mag", 32'(magnitude), 32'd0);
`ifdef TC2SM_OVF_EN
    check("rst ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    run_op("op05", 8'h05, 1'b0, 8'h05, 1'b0);
    run_op("opFB", 8'hFB, 1'b1, 8'h05, 1'b0);
    run_op("op00", 8'h00, 1'b0, 8'h00, 1'b0);
    run_op("op80", 8'h80, 1'b1, 8'h80, 1'b1);
    run_op("op81", 8'h81, 1'b1, 8'h7F, 1'b0);

    // Backpressure with ignored in_valid pulse
    send_and_wait(8'hF0, lat);
    check("bp latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      operand  = 8'h01;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d sign", i), 32'(sign), 32'd1);
      check($sformatf("bp%0d mag", i), 32'(magnitude), 32'h10);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result("bp");
    repeat (2) @(posedge clk);
    #1;
    check("bp no accept in_ready", 32'(in_ready), 32'd1);

    // Reset while bit 3 of 8'hC3 is being processed
    @(negedge clk);
    operand  = 8'hC3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid-rst in_ready", 32'(in_ready), 32'd1);
    check("mid-rst out_valid", 32'(out_valid), 32'd0);
    check("mid-rst mag", 32'(magnitude), 32'd0);
    check("mid-rst sign", 32'(sign), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("opC3", 8'hC3, 1'b1, 8'h3D, 1'b0);

    // Back-to-back with out_ready tied high
    @(negedge clk);
    out_ready = 1'b1;
    operand   = 8'h7F;
    in_valid  = 1'b1;
    @(posedge clk);
    t0 = cyc;
    #1;
    operand = 8'hFF;
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b0 out_valid", 32'(out_valid), 32'd1);
    check("b2b0 sign", 32'(sign), 32'd0);
    check("b2b0 mag", 32'(magnitude), 32'h7F);
    n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    t1 = cyc;
    #1;
    in_valid = 1'b0;
    check("b2b accept spacing", 32'(t1 - t0), 32'd10);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b1 latency", 32'(n), 32'd8);
    check("b2b1 sign", 32'(sign), 32'd1);
    check("b2b1 mag", 32'(magnitude), 32'h01);
    @(negedge clk);
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tc_to_sm.md
# tc_to_sm

Bit-serial decoder from two's-complement to sign-magnitude, the inverse-direction companion of the arithmetic library's two's-complement negator. It accepts one WIDTH-bit two's-complement operand over a valid/ready handshake. It produces the sign and the full unsigned magnitude using a single half-adder cell, processing one bit per clock. It sits between datapath blocks that produce two's-complement results and consumers that need sign-magnitude, such as display and magnitude-compare logic.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand on `operand` is valid.
- in_ready  output  1  block can accept an operand; high only in IDLE.
- operand  input  WIDTH  two's-complement input value.
- out_valid  output  1  `sign`/`magnitude` are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- sign  output  1  1 when the operand was negative (operand MSB).
- magnitude  output  WIDTH  unsigned |operand|; WIDTH bits, so the most-negative value is representable.
- ovf  output  1  present only with TC2SM_OVF_EN; see Configuration.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch operand into the shift register; sign_r <= operand[WIDTH-1]; carry <= operand[WIDTH-1]; bit counter <= 0; go to BUSY.
- BUSY (in_ready=0, out_valid=0): each cycle process bit i (LSB first).
  - x = shreg[0] XOR sign_r.
  - The half adder gives sum = x^carry and cout = x&carry.
  - sum shifts into the MSB of the magnitude register; carry <= cout.
  - The counter increments; when it reaches WIDTH-1, go to DONE on that same edge.
- Positive operand: the inversion and the carry-in are both 0, so magnitude equals operand.
- Negative operand: magnitude = ~operand + 1, computed modulo 2^WIDTH.
- DONE:
  - out_valid=1; sign and magnitude are held stable.
  - When out_ready is high, go to IDLE on that edge.
- in_valid outside IDLE is ignored; the operand is not sampled.
- Results are never dropped or overwritten while out_valid=1 and out_ready=0.
- Most-negative input (only the MSB set): sign=1, magnitude = 2^(WIDTH-1), e.g. 8'h80 gives 8'h80.
- Zero input: sign=0, magnitude=0.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, sign=0, magnitude=0, ovf=0.
  - Carry, counter and shift register are cleared.
- Reset asserted in any state: returns to IDLE on the next edge; any in-flight operand and held result are discarded.
- Reset has priority over all handshakes.
- Latency: the accepting edge is E0. BUSY spans the WIDTH cycles that follow. out_valid is first high after edge E0+WIDTH, i.e. 8 edges later for WIDTH=8.
- Throughput: at best one operand per WIDTH+2 cycles. The DONE->IDLE edge and the next accept edge are distinct, because in_ready is low in DONE.
- All outputs are registered; no combinational path from input to output.

## Configuration
- Macro TC2SM_OVF_EN.
  - When defined: port `ovf` exists. It is high together with out_valid exactly when the operand is the most-negative value, because the magnitude does not fit in WIDTH-1 bits. It is registered and cleared on reset and on the DONE->IDLE transition.
  - When undefined: `ovf` and its logic are absent; all other behaviour is identical.

## Structure
- Shared header tc_defs.vh holds:
  - state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - the default WIDTH constant;
  - the counter width, clog2(WIDTH).
- One sub-module: the existing HalfAdder, instantiated once as the serial carry cell, with its carry-out registered in tc_to_sm.
- Inversion is a single XOR with sign_r; NOT8 is not used.

## Test plan
- Operand 8'h05 accepted: 8 cycles later out_valid=1, sign=0, magnitude=8'h05, ovf=0.
- Operand 8'hFB: sign=1, magnitude=8'h05. Operand 8'h00: sign=0, magnitude=8'h00.
- Operand 8'h80: sign=1, magnitude=8'h80, ovf=1 with TC2SM_OVF_EN. Operand 8'h81: magnitude=8'h7F, ovf=0.
- Backpressure: result for 8'hF0 (magnitude 8'h10) with out_ready held low for 5 cycles. Outputs stay stable and in_ready stays 0. Pulsing in_valid with 8'h01 meanwhile is ignored. Raising out_ready gives IDLE the next cycle.
- Reset mid-operation: assert reset for 1 cycle while processing bit 3 of 8'hC3. Next cycle: state IDLE, out_valid=0, magnitude=0. A following 8'hC3 then gives sign=1, magnitude=8'h3D.
- Back-to-back: 8'h7F then 8'hFF with out_ready tied high give (0, 8'h7F) then (1, 8'h01). The accept edges are WIDTH+2 cycles apart.
